rename_stage: RTL and testbench

//  4-wide register-rename stage that feeds the issue window.
//  - Maps 5-bit architectural sources and destinations to 6-bit physical tags using a speculative RAT, a retirement RAT (RRAT) and a circular free list.
//  - Generates per-source wake bits from a busy table.
//  - Registers one renamed group per cycle into the issue-window input.
//  - Frees physical registers on commit and restores state on flush.

---
 rtl/rename_stage_if.sv | 43 ++++
 rtl/rename_stage.sv | 170 +++++++++++++++++
 tb/tb_rename_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_stage_if.sv
// Rename-stage bus: decoded group in, renamed group out, writeback wake and commit.
interface rename_stage_if #(
    parameter int PAYLOAD_W = 73
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             in_lane_valid;
    logic [3:0]             in_rd_wr;
    logic [19:0]            in_rdst;
    logic [19:0]            in_src1;
    logic [19:0]            in_src2;
    logic [4*PAYLOAD_W-1:0] in_payload;
    logic                   iw_full;
    logic                   out_valid;
    logic [3:0]             out_lane_valid;
    logic [19:0]            out_rdst;
    logic [23:0]            out_phydst;
    logic [23:0]            out_src1;
    logic [23:0]            out_src2;
    logic [3:0]             out_src1_wake;
    logic [3:0]             out_src2_wake;
    logic [4*PAYLOAD_W-1:0] out_payload;
    logic [3:0]             wb_valid;
    logic [23:0]            wb_tag;
    logic                   com_valid;
    logic [4:0]             com_rdst;
    logic [5:0]             com_phy;

    modport master (
        output flush, in_valid, in_lane_valid, in_rd_wr, in_rdst, in_src1, in_src2,
               in_payload, iw_full, wb_valid, wb_tag, com_valid, com_rdst, com_phy,
        input  in_ready, out_valid, out_lane_valid, out_rdst, out_phydst, out_src1,
               out_src2, out_src1_wake, out_src2_wake, out_payload
    );

    modport slave (
        input  flush, in_valid, in_lane_valid, in_rd_wr, in_rdst, in_src1, in_src2,
               in_payload, iw_full, wb_valid, wb_tag, com_valid, com_rdst, com_phy,
        output in_ready, out_valid, out_lane_valid, out_rdst, out_phydst, out_src1,
               out_src2, out_src1_wake, out_src2_wake, out_payload
    );
endinterface

// File: rtl/rename_stage.sv
// 4-wide rename stage: RAT/RRAT, circular free list, busy table, registered issue output.
// Optional free-list error checking (sticky err output) when RENAME_FREELIST_CHECK_EN is defined.
module rename_stage #(
    parameter int PAYLOAD_W = 73
) (
    input  logic clk,
    input  logic rst,
`ifdef RENAME_FREELIST_CHECK_EN
    output logic err,
`endif
    rename_stage_if.slave bus
);
    typedef logic [5:0] tag_t;

    tag_t        rat  [32];
    tag_t        rrat [32];
    tag_t        fl   [32];
    logic [5:0]  head, tail, com_head, count;
    logic [63:0] busy;

    logic                   o_valid;
    logic [3:0]             o_lv, o_w1, o_w2;
    logic [19:0]            o_rdst;
    logic [23:0]            o_phy, o_s1, o_s2;
    logic [4*PAYLOAD_W-1:0] o_pay;

    logic       fire, commit;
    logic [3:0] alloc;
    logic [2:0] n_alloc;
    logic [4:0] rd_a  [4];
    logic [4:0] src_a [2][4];
    tag_t       new_tag [4];
    tag_t       src_tag [2][4];
    logic [3:0] src_wake [2];
    logic [23:0] phy_pk;
    logic [23:0] src_pk [2];

    function automatic logic wb_hit(input tag_t t, input logic [3:0] v, input logic [23:0] tags);
        wb_hit = 1'b0;
        for (int unsigned j = 0; j < 4; j++)
            if (v[j] && tags[6*j +: 6] == t && t != '0) wb_hit = 1'b1;
    endfunction

    assign count         = tail - head;
    assign bus.in_ready  = (count >= 6'd4) && !(o_valid && bus.iw_full) && !bus.flush;
    assign fire          = bus.in_valid && bus.in_ready;
    assign commit        = bus.com_valid && (bus.com_rdst != '0);

    always_comb begin
        n_alloc = '0;
        phy_pk  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            rd_a[k]     = bus.in_rdst[5*k +: 5];
            src_a[0][k] = bus.in_src1[5*k +: 5];
            src_a[1][k] = bus.in_src2[5*k +: 5];
            alloc[k]    = bus.in_lane_valid[k] && bus.in_rd_wr[k] && (rd_a[k] != '0);
            new_tag[k]  = fl[5'(head + {3'b0, n_alloc})];
            if (alloc[k]) begin
                phy_pk[6*k +: 6] = new_tag[k];
                n_alloc          = n_alloc + 3'd1;
            end
        end
        // Later matching lanes overwrite earlier ones, so the newest in-group producer wins.
        for (int unsigned s = 0; s < 2; s++) begin
            src_pk[s]   = '0;
            src_wake[s] = '0;
            for (int unsigned k = 0; k < 4; k++) begin
                src_tag[s][k] = rat[src_a[s][k]];
                src_wake[s][k] = !busy[rat[src_a[s][k]]] ||
                                 wb_hit(rat[src_a[s][k]], bus.wb_valid, bus.wb_tag);
                for (int unsigned j = 0; j < k; j++) begin
                    if (alloc[j] && rd_a[j] == src_a[s][k]) begin
                        src_tag[s][k]  = new_tag[j];
                        src_wake[s][k] = 1'b0;
                    end
                end
                if (src_a[s][k] == '0) begin
                    src_tag[s][k]  = '0;
                    src_wake[s][k] = 1'b1;
                end
                src_pk[s][6*k +: 6] = src_tag[s][k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                rat[i]  <= 6'(i);
                rrat[i] <= 6'(i);
                fl[i]   <= 6'(i + 32);
            end
            head     <= '0;
            tail     <= 6'd32;
            com_head <= '0;
            busy     <= '0;
            o_valid  <= 1'b0;
            o_lv     <= '0;
            o_rdst   <= '0;
            o_phy    <= '0;
            o_s1     <= '0;
            o_s2     <= '0;
            o_w1     <= '0;
            o_w2     <= '0;
            o_pay    <= '0;
        end else begin
            for (int unsigned j = 0; j < 4; j++)
                if (bus.wb_valid[j] && bus.wb_tag[6*j +: 6] != '0)
                    busy[bus.wb_tag[6*j +: 6]] <= 1'b0;
            if (commit) begin
                fl[tail[4:0]]      <= rrat[bus.com_rdst];
                rrat[bus.com_rdst] <= bus.com_phy;
                tail               <= tail + 6'd1;
                com_head           <= com_head + 6'd1;
            end
            if (bus.flush) begin
                // Restore from the RRAT as it stands after this cycle's commit.
                for (int unsigned i = 0; i < 32; i++)
                    rat[i] <= (commit && bus.com_rdst == 5'(i)) ? bus.com_phy : rrat[i];
                head    <= com_head + {5'b0, commit};
                busy    <= '0;
                o_valid <= 1'b0;
            end else if (fire) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (alloc[k]) begin
                        rat[rd_a[k]]     <= new_tag[k];
                        busy[new_tag[k]] <= 1'b1;
                    end
                end
                head    <= head + {3'b0, n_alloc};
                o_valid <= 1'b1;
                o_lv    <= bus.in_lane_valid;
                o_rdst  <= bus.in_rdst;
                o_phy   <= phy_pk;
                o_s1    <= src_pk[0];
                o_s2    <= src_pk[1];
                o_w1    <= src_wake[0];
                o_w2    <= src_wake[1];
                o_pay   <= bus.in_payload;
            end else begin
                if (!bus.iw_full) o_valid <= 1'b0;
                for (int unsigned k = 0; k < 4; k++) begin
                    o_w1[k] <= o_w1[k] | wb_hit(o_s1[6*k +: 6], bus.wb_valid, bus.wb_tag);
                    o_w2[k] <= o_w2[k] | wb_hit(o_s2[6*k +: 6], bus.wb_valid, bus.wb_tag);
                end
            end
        end
    end

`ifdef RENAME_FREELIST_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if ((commit && count == 6'd32) ||
                 (commit && rrat[bus.com_rdst] == '0) ||
                 (fire && count < {3'b0, n_alloc}))
            err <= 1'b1;
    end
`endif

    assign bus.out_valid      = o_valid;
    assign bus.out_lane_valid = o_lv;
    assign bus.out_rdst       = o_rdst;
    assign bus.out_phydst     = o_phy;
    assign bus.out_src1       = o_s1;
    assign bus.out_src2       = o_s2;
    assign bus.out_src1_wake  = o_w1;
    assign bus.out_src2_wake  = o_w2;
    assign bus.out_payload    = o_pay;
endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: directed groups, flush, commit and free-list wrap.
module tb_rename_stage;
    localparam int PW = 73;

    typedef struct {
        logic [3:0]      lv;
        logic [19:0]     rdst;
        logic [23:0]     phy, s1, s2;
        logic [3:0]      w1, w2;
        logic [4*PW-1:0] pay;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
`ifdef RENAME_FREELIST_CHECK_EN
    logic err;
`endif
    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   gid   = 0;

    always #5 clk = ~clk;

    rename_stage_if #(.PAYLOAD_W(PW)) bus ();

    rename_stage #(.PAYLOAD_W(PW)) dut (
        .clk (clk),
        .rst (rst),
`ifdef RENAME_FREELIST_CHECK_EN
        .err (err),
`endif
        .bus (bus)
    );

    function automatic logic [19:0] a5(input int unsigned l0, l1, l2, l3);
        return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    endfunction

    function automatic logic [23:0] t6(input int unsigned l0, l1, l2, l3);
        return {6'(l3), 6'(l2), 6'(l1), 6'(l0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] lv, rw, input logic [19:0] rd, s1, s2,
                        input logic [23:0] ephy, es1, es2, input logic [3:0] ew1, ew2);
        exp_t          e;
        logic [PW-1:0] p;
        bit            ok;
        p      = PW'(gid * 97 + 5);
        gid++;
        e.lv   = lv;
        e.rdst = rd;
        e.phy  = ephy;
        e.s1   = es1;
        e.s2   = es2;
        e.w1   = ew1;
        e.w2   = ew2;
        e.pay  = {p + PW'(3), p + PW'(2), p + PW'(1), p};
        bus.in_valid      = 1'b1;
        bus.in_lane_valid = lv;
        bus.in_rd_wr      = rw;
        bus.in_rdst       = rd;
        bus.in_src1       = s1;
        bus.in_src2       = s2;
        bus.in_payload    = e.pay;
        q.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout group %0d: in_ready 0 expected 1", gid - 1);
            void'(q.pop_back());
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [5:0] phy);
        bus.com_valid = 1'b1;
        bus.com_rdst  = rd;
        bus.com_phy   = phy;
        tick();
        bus.com_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.out_valid && !bus.iw_full) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_group: out_valid 1 with empty scoreboard");
            end else begin
                e = q.pop_front();
                chk("out_lane_valid", 64'(bus.out_lane_valid), 64'(e.lv));
                chk("out_rdst", 64'(bus.out_rdst), 64'(e.rdst));
                chk("out_phydst", 64'(bus.out_phydst), 64'(e.phy));
                chk("out_src1", 64'(bus.out_src1), 64'(e.s1));
                chk("out_src2", 64'(bus.out_src2), 64'(e.s2));
                chk("out_src1_wake", 64'(bus.out_src1_wake), 64'(e.w1));
                chk("out_src2_wake", 64'(bus.out_src2_wake), 64'(e.w2));
                tests++;
                if (bus.out_payload !== e.pay) begin
                    fails++;
                    $display("FAIL out_payload: got %0h expected %0h", bus.out_payload, e.pay);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_lane_valid = '0; bus.in_rd_wr = '0;
        bus.in_rdst = '0; bus.in_src1 = '0; bus.in_src2 = '0; bus.in_payload = '0;
        bus.iw_full = 1'b0; bus.wb_valid = '0; bus.wb_tag = '0;
        bus.com_valid = 1'b0; bus.com_rdst = '0; bus.com_phy = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_phydst", 64'(bus.out_phydst), 64'd0);
`ifdef RENAME_FREELIST_CHECK_EN
        chk("reset_err", 64'(err), 64'd0);
`endif
        tick();

        // Full group, bypass and wake mix.
        send(4'hF, 4'hF, a5(1, 2, 3, 4), a5(5, 1, 3, 2), a5(0, 31, 0, 1),
             t6(32, 33, 34, 35), t6(5, 32, 3, 33), t6(0, 31, 0, 32), 4'b0101, 4'b0111);
        // Same-rdst lanes, non-writing lanes, arch-0 source.
        send(4'hF, 4'b1011, a5(5, 5, 6, 0), a5(1, 5, 0, 5), a5(5, 2, 7, 4),
             t6(36, 37, 0, 0), t6(32, 36, 0, 37), t6(5, 33, 7, 35), 4'b0100, 4'b0101);

        // Writeback in the rename cycle, then a wake while held.
        bus.wb_valid = 4'b0001;
        bus.wb_tag   = t6(32, 0, 0, 0);
        send(4'b0001, 4'b0010, a5(0, 9, 0, 0), a5(1, 0, 0, 0), a5(2, 0, 0, 0),
             t6(0, 0, 0, 0), t6(32, 0, 0, 0), t6(33, 0, 0, 0), 4'b1111, 4'b1111);
        bus.wb_valid = '0;
        bus.iw_full  = 1'b1;
        @(negedge clk);
        chk("held_wake_before", 64'(bus.out_src2_wake), 64'b1110);
        chk("held_in_ready", 64'(bus.in_ready), 64'd0);
        chk("held_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        bus.wb_valid = 4'b0010;
        bus.wb_tag   = t6(0, 33, 0, 0);
        tick();
        bus.wb_valid = '0;
        @(negedge clk);
        chk("held_wake_after", 64'(bus.out_src2_wake), 64'b1111);
        tick();
        bus.iw_full = 1'b0;
        tick();

        do_flush();
        send(4'b0011, 4'b0001, a5(7, 0, 0, 0), a5(7, 1, 4, 0), a5(0, 7, 0, 0),
             t6(32, 0, 0, 0), t6(7, 1, 4, 0), t6(0, 32, 0, 0), 4'b1111, 4'b1101);
        do_flush();
        send(4'b0001, 4'b0001, a5(7, 0, 0, 0), a5(7, 0, 0, 0), a5(0, 0, 0, 0),
             t6(32, 0, 0, 0), t6(7, 0, 0, 0), t6(0, 0, 0, 0), 4'b1111, 4'b1111);
        do_flush();

        // Drain the free list completely.
        for (int unsigned g = 0; g < 8; g++)
            send(4'hF, 4'hF, a5(8, 9, 10, 11), '0, '0,
                 t6(32 + 4*g, 33 + 4*g, 34 + 4*g, 35 + 4*g), '0, '0, 4'hF, 4'hF);
        @(negedge clk);
        chk("empty_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        commit(5'd1, 6'd32);
        @(negedge clk);
        chk("count1_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        commit(5'd2, 6'd33);
        commit(5'd3, 6'd34);
        @(negedge clk);
        chk("count3_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        commit(5'd4, 6'd35);
        @(negedge clk);
        chk("count4_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        // Allocation wraps onto the freed tags 1..4.
        send(4'hF, 4'hF, a5(12, 13, 14, 15), a5(0, 12, 0, 0), '0,
             t6(1, 2, 3, 4), t6(0, 1, 0, 0), '0, 4'b1101, 4'hF);

        // Flush with a same-cycle commit restores the post-commit RRAT.
        bus.flush     = 1'b1;
        bus.com_valid = 1'b1;
        bus.com_rdst  = 5'd5;
        bus.com_phy   = 6'd36;
        tick();
        bus.flush     = 1'b0;
        bus.com_valid = 1'b0;
        send(4'b0001, 4'b0001, a5(6, 0, 0, 0), a5(5, 0, 0, 0), a5(1, 0, 0, 0),
             t6(37, 0, 0, 0), t6(36, 0, 0, 0), t6(32, 0, 0, 0), 4'hF, 4'hF);
        repeat (3) tick();

`ifdef RENAME_FREELIST_CHECK_EN
        @(negedge clk);
        chk("err_clear", 64'(err), 64'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        commit(5'd1, 6'd32);
        @(negedge clk);
        chk("err_overflow", 64'(err), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("err_after_rst", 64'(err), 64'd0);
        tick();
        rst = 1'b0;
        tick();
`endif

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d groups left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
